logit_quantizer: RTL and testbench

- Collects the per-class accumulator results of the final fully-connected layer. They arrive as a serial stream of wide signed partial sums, one class per beat.
- Requantizes each sum to BITWIDTH signed with an arithmetic right shift and saturation.
- Packs the results into one CLASSES×BITWIDTH logit vector and presents it to the downstream argmax stage.
- The output vector is held stable for the whole time the argmax stage scans it. A new frame can fill while the previous vector is held.

---
 rtl/logit_quantizer.sv | 124 ++++++++++++
 tb/tb_logit_quantizer.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/logit_quantizer.sv
// Requantizes a serial stream of per-class accumulators to BITWIDTH signed logits
// and hands the packed vector to the argmax stage. Optional macro: LOGIT_ROUND_EN.
module logit_quantizer #(
  parameter int BITWIDTH    = 8,
  parameter int ACC_WIDTH   = 32,
  parameter int SHIFT       = 8,
  parameter int CLASSES     = 10,
  parameter int INDEX_WIDTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [ACC_WIDTH-1:0]         in_data,
  input  logic                         in_last,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [BITWIDTH*CLASSES-1:0]  data_o,
  output logic                         frame_err
);

  // Handshakes: a beat or vector transfers on the rising edge where valid && ready;
  // valid never depends on ready, and in_ready depends only on state_q.
  typedef enum logic {FILL, HOLD} state_t;

  localparam logic [INDEX_WIDTH-1:0] LAST_IDX = INDEX_WIDTH'(CLASSES - 1);
  localparam logic signed [ACC_WIDTH:0] SAT_MAX = (ACC_WIDTH+1)'((1 << (BITWIDTH - 1)) - 1);
  localparam logic signed [ACC_WIDTH:0] SAT_MIN = ~SAT_MAX;

  state_t                     state_q, state_d;
  logic [INDEX_WIDTH-1:0]     cnt;
  logic                       armed;
  logic                       accept;
  logic                       load;
  logic [BITWIDTH-1:0]        fill_buf [CLASSES];
  logic [BITWIDTH*CLASSES-1:0] fill_vec;

  logic signed [ACC_WIDTH:0]  acc_ext, acc_sum, acc_shr;
  logic [BITWIDTH-1:0]        q_sat;

  assign acc_ext = {in_data[ACC_WIDTH-1], in_data};

`ifdef LOGIT_ROUND_EN
  // Half-LSB offset; the extra sign bit keeps the sum from wrapping.
  localparam logic signed [ACC_WIDTH:0] RND =
    (SHIFT == 0) ? '0 : ((ACC_WIDTH+1)'(1) << ((SHIFT == 0) ? 0 : SHIFT - 1));
  assign acc_sum = acc_ext + RND;
`else
  assign acc_sum = acc_ext;
`endif

  assign acc_shr = acc_sum >>> SHIFT;

  always_comb begin
    q_sat = acc_shr[BITWIDTH-1:0];
    if (acc_shr > SAT_MAX)
      q_sat = SAT_MAX[BITWIDTH-1:0];
    else if (acc_shr < SAT_MIN)
      q_sat = SAT_MIN[BITWIDTH-1:0];
  end

  always_comb begin
    fill_vec = '0;
    for (int k = 0; k < CLASSES; k++)
      fill_vec[BITWIDTH*(CLASSES-k)-1 -: BITWIDTH] = fill_buf[k];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= FILL;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    load     = 1'b0;
    case (state_q)
      FILL: begin
        in_ready = 1'b1;
        if (in_valid && cnt == LAST_IDX) state_d = HOLD;
      end
      HOLD: begin
        if (!out_valid && out_ready && armed) begin
          load    = 1'b1;
          state_d = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  assign accept = in_valid && in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      out_valid <= 1'b0;
      data_o    <= '0;
      frame_err <= 1'b0;
      armed     <= 1'b1;
      for (int k = 0; k < CLASSES; k++) fill_buf[k] <= '0;
    end else begin
      if (accept) begin
        for (int k = 0; k < CLASSES; k++)
          if (cnt == INDEX_WIDTH'(k)) fill_buf[k] <= q_sat;
        cnt <= (cnt == LAST_IDX) ? '0 : cnt + INDEX_WIDTH'(1);
        if (in_last != (cnt == LAST_IDX)) frame_err <= 1'b1;
      end

      if (load) begin
        data_o    <= fill_vec;
        out_valid <= 1'b1;
        cnt       <= '0;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end

      // Ready stays high one cycle after a handshake; only a low ready re-arms.
      if (out_valid && out_ready) armed <= 1'b0;
      else if (!out_ready)        armed <= 1'b1;
    end
  end

endmodule

// File: tb/tb_logit_quantizer.sv
// Self-checking bench for logit_quantizer: vector table, scoreboard queue on the
// output handshake, and hand-written held-vector, framing-error and reset sequences.
module tb_logit_quantizer;

  localparam int BW  = 8;
  localparam int AW  = 32;
  localparam int SH  = 8;
  localparam int CL  = 10;
  localparam int IW  = 4;
  localparam int VW  = BW * CL;

  typedef logic signed [AW-1:0] frame_t [CL];
  typedef struct {
    logic signed [AW-1:0] d;
    logic [BW-1:0]        e_tr;
    logic [BW-1:0]        e_rd;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [AW-1:0] in_data = '0;
  logic          in_last = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [VW-1:0] data_o;
  logic          frame_err;

  logic [VW-1:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;
  int n_out = 0;

  logit_quantizer #(
    .BITWIDTH(BW), .ACC_WIDTH(AW), .SHIFT(SH), .CLASSES(CL), .INDEX_WIDTH(IW)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid),
    .out_ready(out_ready), .data_o(data_o), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [BW-1:0] requant(input logic signed [AW-1:0] d);
    longint x;
    x = longint'(d);
`ifdef LOGIT_ROUND_EN
    if (SH > 0) x = x + (longint'(1) <<< (SH - 1));
`endif
    x = x >>> SH;
    if (x > longint'(2**(BW-1) - 1)) x = longint'(2**(BW-1) - 1);
    else if (x < -longint'(2**(BW-1))) x = -longint'(2**(BW-1));
    return x[BW-1:0];
  endfunction

  function automatic logic [VW-1:0] model_vec(input frame_t d);
    logic [VW-1:0] v;
    v = '0;
    for (int k = 0; k < CL; k++) v[BW*(CL-k)-1 -: BW] = requant(d[k]);
    return v;
  endfunction

  // Scoreboard: every vector handed over is compared with the oldest expectation.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_output: got %h expected none", data_o);
      end else begin
        chk("frame_out", data_o, exp_q.pop_front());
      end
      n_out++;
    end
  end

  task automatic send_beat(input logic signed [AW-1:0] d, input logic l);
    int waitc;
    waitc = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    while (!in_ready && waitc < 200) begin
      @(negedge clk);
      in_data = $urandom;
      in_data = d;
      waitc++;
    end
    if (!in_ready) begin
      n_cmp++;
      n_err++;
      $display("FAIL beat_timeout: got in_ready=0 expected 1 within 200 cycles");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = $urandom;
  endtask

  task automatic send_frame(input frame_t d, input logic [VW-1:0] exp);
    exp_q.push_back(exp);
    for (int k = 0; k < CL; k++) send_beat(d[k], k == CL - 1);
  endtask

  task automatic wait_handshake(input int start);
    int waitc;
    waitc = 0;
    while (n_out == start && waitc < 200) begin
      @(posedge clk);
      waitc++;
    end
    if (n_out == start) begin
      n_cmp++;
      n_err++;
      $display("FAIL handshake_timeout: got no output expected one within 200 cycles");
    end
  endtask

  // Downstream scan: ready dropped for a few cycles right after each handshake.
  task automatic drain(input int start);
    wait_handshake(start);
    #1 out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 out_ready = 1'b1;
  endtask

  initial begin
    vec_t          tbl [CL];
    frame_t        fr, fa, fb;
    logic [VW-1:0] v, va, vb;
    logic          b_done;
    int            st, waitc;

    tbl[0] = '{32'sh0001_0000, 8'h7F, 8'h7F};
    tbl[1] = '{-32'sh0001_0000, 8'h80, 8'h80};
    tbl[2] = '{-32'sd1,        8'hFF, 8'h00};
    tbl[3] = '{32'sd384,       8'h01, 8'h02};
    tbl[4] = '{32'sd383,       8'h01, 8'h01};
    tbl[5] = '{32'sd0,         8'h00, 8'h00};
    tbl[6] = '{32'sd255,       8'h00, 8'h01};
    tbl[7] = '{32'sd32767,     8'h7F, 8'h7F};
    tbl[8] = '{-32'sd32768,    8'h80, 8'h80};
    tbl[9] = '{-32'sd384,      8'hFE, 8'hFF};

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_data_o", data_o, 0);
    chk("rst_frame_err", frame_err, 0);
    rst = 1'b0;

    // Basic frame: slot k = k, out_valid one edge after the last beat
    v = '0;
    for (int k = 0; k < CL; k++) begin
      fr[k] = 32'(256 * k);
      v[BW*(CL-k)-1 -: BW] = 8'(k);
    end
    st = n_out;
    send_frame(fr, v);
    chk("lat_no_valid_yet", out_valid, 0);
    chk("lat_hold_ready", in_ready, 0);
    @(posedge clk);
    #1;
    chk("lat_valid", out_valid, 1);
    chk("basic_msb", data_o[VW-1 -: BW], 0);
    drain(st);

    // Table frame: saturation and rounding corners
    v = '0;
    for (int k = 0; k < CL; k++) begin
      fr[k] = tbl[k].d;
`ifdef LOGIT_ROUND_EN
      v[BW*(CL-k)-1 -: BW] = tbl[k].e_rd;
`else
      v[BW*(CL-k)-1 -: BW] = tbl[k].e_tr;
`endif
    end
    st = n_out;
    send_frame(fr, v);
    drain(st);
    for (int k = 0; k < CL; k++) begin
`ifdef LOGIT_ROUND_EN
      chk($sformatf("tbl_slot%0d", k), data_o[BW*(CL-k)-1 -: BW], tbl[k].e_rd);
`else
      chk($sformatf("tbl_slot%0d", k), data_o[BW*(CL-k)-1 -: BW], tbl[k].e_tr);
`endif
    end

    // Random frames against the model
    for (int f = 0; f < 3; f++) begin
      for (int k = 0; k < CL; k++)
        fr[k] = (f == 2) ? 32'($urandom) : 32'($urandom_range(0, 65535)) - 32'sd32768;
      st = n_out;
      send_frame(fr, model_vec(fr));
      drain(st);
    end
    chk("no_frame_err_yet", frame_err, 0);

    // Held-vector protection: B fills while A is scanned; B waits for re-arm
    for (int k = 0; k < CL; k++) begin
      fa[k] = 32'($urandom_range(0, 65535)) - 32'sd32768;
      fb[k] = 32'($urandom_range(0, 65535)) - 32'sd32768;
    end
    va = model_vec(fa);
    vb = model_vec(fb);
    b_done = 1'b0;
    st = n_out;
    send_frame(fa, va);
    fork
      begin
        send_frame(fb, vb);
        b_done = 1'b1;
      end
      begin
        wait_handshake(st);
        @(posedge clk);
        #1 out_ready = 1'b0;
        for (int i = 0; i < 12; i++) begin
          @(negedge clk);
          chk("hold_data", data_o, va);
          if (b_done) chk("hold_in_ready", in_ready, 0);
        end
        @(negedge clk);
        chk("b_filled", b_done, 1);
        chk("hold_data_last", data_o, va);
        chk("hold_no_valid", out_valid, 0);
        st = n_out;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("b_load_valid", out_valid, 1);
        chk("b_load_data", data_o, vb);
        drain(st);
      end
    join

    // Framing error: in_last on beat 5
    for (int k = 0; k < CL; k++) fr[k] = 32'($urandom_range(0, 65535)) - 32'sd32768;
    exp_q.push_back(model_vec(fr));
    st = n_out;
    for (int k = 0; k < CL; k++) begin
      send_beat(fr[k], k == 5);
      if (k == 4) chk("ferr_before", frame_err, 0);
      if (k == 5) chk("ferr_set", frame_err, 1);
    end
    chk("ferr_frame_hold", in_ready, 0);
    drain(st);
    chk("ferr_sticky", frame_err, 1);

    // Reset mid-frame after beat 4
    for (int k = 0; k < 5; k++) send_beat(32'sd1000 * k, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_data_o", data_o, 0);
    chk("mid_rst_frame_err", frame_err, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < CL; k++) fr[k] = 32'($urandom_range(0, 65535)) - 32'sd32768;
    st = n_out;
    send_frame(fr, model_vec(fr));
    drain(st);
    chk("post_rst_frame_err", frame_err, 0);

    waitc = 0;
    while (exp_q.size() != 0 && waitc < 100) begin
      @(posedge clk);
      waitc++;
    end
    chk("queue_empty", VW'(exp_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
